// File: rtl/cc_pkg.sv
// Shared constants, word type and pointer-width helper for the capture stage.
package cc_pkg;

    // Six gated decode lanes, LSB = first lane.
    localparam int CC_WORD_W     = 6;
    localparam int CC_FIFO_DEPTH = 4;

    typedef logic [CC_WORD_W-1:0] cc_word_t;

    // Pointer width for a power-of-two FIFO depth; never narrower than 1 bit.
    function automatic int cc_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : cc_pkg

// File: rtl/cc_capture_fifo_if.sv
// Producer/consumer bundle of the capture FIFO. The slave side is the FIFO.
interface cc_capture_fifo_if
    import cc_pkg::*;
#(
    parameter int WIDTH = CC_WORD_W,
    parameter int DEPTH = CC_FIFO_DEPTH
);

    // Capture side, driven by the decode stage.
    logic                     strobe;
    logic                     en;
    logic [WIDTH-1:0]         din;
    logic                     clr;

    // Consumer side.
    logic                     out_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;

    // Status.
    logic [cc_ptr_w(DEPTH):0] count;
    logic                     full;
    logic                     empty;
    logic                     overflow;

    modport master (
        output strobe, en, din, clr, out_ready,
        input  out_valid, out_data, count, full, empty, overflow
    );

    modport slave (
        input  strobe, en, din, clr, out_ready,
        output out_valid, out_data, count, full, empty, overflow
    );

endinterface : cc_capture_fifo_if

// File: rtl/cc_edge_detect.sv
// Rising-edge detector on the capture strobe, qualified by the decode enable.
// The strobe history register tracks the strobe regardless of enable, so an
// enable that rises while the strobe is already high does not create a capture.
module cc_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    input  logic en,
    output logic cap
);

    logic strobe_q;

    // Remember last cycle's strobe level; reset to 0 so a strobe already high
    // right after reset counts as an edge.
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // a blocking = here would let later readers in the same edge see the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe;
        end
    end

    assign cap = strobe & ~strobe_q & en;

endmodule : cc_edge_detect

// File: rtl/cc_capture_fifo.sv
// Capture FIFO: buffers gated decode words on qualified strobe edges and
// presents them first-word-fall-through on a valid/ready handshake.
// Occupancy is kept in its own counter so full and empty never alias.
// All outputs are decoded from registers only.
module cc_capture_fifo
    import cc_pkg::*;
#(
    parameter int WIDTH = CC_WORD_W,
    parameter int DEPTH = CC_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    cc_capture_fifo_if.slave    bus
);

    localparam int PTR_W = cc_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    logic             cap;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             drop;

    cc_edge_detect u_edge (
        .clk    (clk),
        .rst    (rst),
        .strobe (bus.strobe),
        .en     (bus.en),
        .cap    (cap)
    );

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Handshake decode. A pop frees the slot the push needs, so push and pop
    // together are legal when full; a pop into an empty FIFO cannot happen
    // because out_valid is low.
    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        drop = 1'b0;
        pop  = ~empty & bus.out_ready;
        push = cap & (~full | pop);
        drop = cap & full & ~pop;
    end

    // Storage write. Entries carry no reset: out_data is masked while empty,
    // so stale contents are never observable.
    // NOTE: the data array is deliberately left out of the reset so it maps to
    // plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // Pointers wrap modulo DEPTH through natural overflow of PTR_W bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (bus.clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? '0 : mem[rd_ptr];
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.overflow  = overflow_q;

endmodule : cc_capture_fifo

// File: tb/tb_cc_capture_fifo.sv
// Directed self-checking bench for cc_capture_fifo. Inputs change and outputs
// are observed on the falling clock edge, away from the capturing edge.
module tb_cc_capture_fifo;

    localparam int WIDTH = 6;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    cc_capture_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    cc_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One strobe pulse: high for one cycle, low for one cycle.
    task automatic pulse(input logic [WIDTH-1:0] d);
        bus.din    = d;
        bus.strobe = 1'b1;
        @(negedge clk);
        bus.strobe = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.strobe    = 1'b0;
        bus.en        = 1'b1;
        bus.din       = '0;
        bus.clr       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (bus.count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        tests_run++; if (bus.out_data !== 6'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", bus.out_data); end
        tests_run++; if (bus.empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        tests_run++; if (bus.full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_capture();
        bus.din    = 6'h2A;
        bus.strobe = 1'b1;
        @(negedge clk);
        tests_run++; if (bus.count !== 3'd1) begin tests_failed++; $display("FAIL single_count: got %0d expected 1", bus.count); end
        tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %b expected 1", bus.out_valid); end
        tests_run++; if (bus.out_data !== 6'h2A) begin tests_failed++; $display("FAIL single_data: got %h expected 2a", bus.out_data); end
        bus.din = 6'h15;
        repeat (2) @(negedge clk);
        tests_run++; if (bus.count !== 3'd1) begin tests_failed++; $display("FAIL single_held_count: got %0d expected 1", bus.count); end
        tests_run++; if (bus.out_data !== 6'h2A) begin tests_failed++; $display("FAIL single_held_data: got %h expected 2a", bus.out_data); end
        bus.strobe = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        tests_run++; if (bus.empty !== 1'b1) begin tests_failed++; $display("FAIL single_drain_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 4; i++) pulse(WIDTH'(i));
        tests_run++; if (bus.full !== 1'b1) begin tests_failed++; $display("FAIL fill_full: got %b expected 1", bus.full); end
        tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL fill_no_overflow: got %b expected 0", bus.overflow); end
        pulse(6'h05);
        tests_run++; if (bus.overflow !== 1'b1) begin tests_failed++; $display("FAIL fill_overflow: got %b expected 1", bus.overflow); end
        tests_run++; if (bus.count !== 3'd4) begin tests_failed++; $display("FAIL fill_drop_count: got %0d expected 4", bus.count); end
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tests_run++; if (bus.out_data !== WIDTH'(i)) begin tests_failed++; $display("FAIL fill_drain_%0d: got %h expected %h", i, bus.out_data, WIDTH'(i)); end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        tests_run++; if (bus.empty !== 1'b1) begin tests_failed++; $display("FAIL fill_end_empty: got %b expected 1", bus.empty); end
        tests_run++; if (bus.out_data !== 6'h00) begin tests_failed++; $display("FAIL fill_end_data: got %h expected 00", bus.out_data); end
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL fill_clr: got %b expected 0", bus.overflow); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) pulse(6'h10 + WIDTH'(i));
        bus.din       = 6'h3F;
        bus.strobe    = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.strobe    = 1'b0;
        bus.out_ready = 1'b0;
        tests_run++; if (bus.count !== 3'd4) begin tests_failed++; $display("FAIL pp_count: got %0d expected 4", bus.count); end
        tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL pp_overflow: got %b expected 0", bus.overflow); end
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [WIDTH-1:0] exp;
            exp = (i == 3) ? 6'h3F : 6'h11 + WIDTH'(i);
            tests_run++; if (bus.out_data !== exp) begin tests_failed++; $display("FAIL pp_drain_%0d: got %h expected %h", i, bus.out_data, exp); end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        tests_run++; if (bus.empty !== 1'b1) begin tests_failed++; $display("FAIL pp_end_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_enable_gating();
        bus.en        = 1'b0;
        bus.din       = 6'h07;
        bus.strobe    = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.en = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (bus.count !== 3'd0) begin tests_failed++; $display("FAIL gate_count: got %0d expected 0", bus.count); end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL gate_valid: got %b expected 0", bus.out_valid); end
        bus.strobe    = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clear_priority();
        for (int i = 0; i < 4; i++) pulse(6'h20 + WIDTH'(i));
        bus.din    = 6'h01;
        bus.strobe = 1'b1;
        bus.clr    = 1'b1;
        @(negedge clk);
        bus.strobe = 1'b0;
        bus.clr    = 1'b0;
        tests_run++; if (bus.overflow !== 1'b1) begin tests_failed++; $display("FAIL clr_drop_wins: got %b expected 1", bus.overflow); end
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL clr_alone: got %b expected 0", bus.overflow); end
        tests_run++; if (bus.count !== 3'd4) begin tests_failed++; $display("FAIL clr_count: got %0d expected 4", bus.count); end
    endtask

    task automatic test_reset_mid_and_wrap();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        tests_run++; if (bus.count !== 3'd3) begin tests_failed++; $display("FAIL mid_pre_count: got %0d expected 3", bus.count); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (bus.count !== 3'd0) begin tests_failed++; $display("FAIL mid_count: got %0d expected 0", bus.count); end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid: got %b expected 0", bus.out_valid); end
        tests_run++; if (bus.out_data !== 6'h00) begin tests_failed++; $display("FAIL mid_data: got %h expected 00", bus.out_data); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            logic [WIDTH-1:0] d;
            d = 6'h30 ^ WIDTH'(k * 5);
            pulse(d);
            tests_run++; if (bus.out_data !== d || bus.count !== 3'd1) begin tests_failed++; $display("FAIL wrap_%0d: got %h/%0d expected %h/1", k, bus.out_data, bus.count, d); end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
        tests_run++; if (bus.empty !== 1'b1) begin tests_failed++; $display("FAIL wrap_end_empty: got %b expected 1", bus.empty); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single_capture();
        test_fill_overflow();
        test_full_push_pop();
        test_enable_gating();
        test_clear_priority();
        test_reset_mid_and_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_cc_capture_fifo
